// File: rtl/cluster_io_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : cluster_io_pkg
// Shared frame geometry and FSM state type for the cluster stimulus writer.
// Revision: 1.0  initial release
// ============================================================================
package cluster_io_pkg;

    localparam int FRAME_W   = 1894;
    localparam int WORD_W    = 32;
    localparam int NWORDS    = (FRAME_W + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = FRAME_W - (NWORDS - 1) * WORD_W;
    localparam int IDX_W     = $clog2(NWORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : cluster_io_pkg
`default_nettype wire

// File: rtl/cluster_frame_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cluster_frame_slot
// Output frame register with valid/ready handshake and delivered-frame count.
// Revision: 1.0  initial release
// ============================================================================
module cluster_frame_slot
    import cluster_io_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               m_ready_i,
    output logic               m_valid_o,
    output logic [FRAME_W-1:0] m_frame_o,
    output logic [CNT_W-1:0]   frame_cnt_o
);

    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // A load is only requested when the slot is empty or handing off this
    // cycle, so load overrides the handshake's valid drop.
    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
        end
        if (load_i) begin
            valid_d = 1'b1;
            frame_d = frame_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_valid_o   = valid_q;
    assign m_frame_o   = frame_q;
    assign frame_cnt_o = cnt_q;

endmodule : cluster_frame_slot
`default_nettype wire

// File: rtl/cluster_frame_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cluster_frame_assembler
// Packs a word stream into double-buffered 1894-bit cluster stimulus frames.
// Revision: 1.0  initial release
// ============================================================================
module cluster_frame_assembler
    import cluster_io_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [WORD_W-1:0]  s_data_i,
    input  logic               s_last_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [FRAME_W-1:0] m_frame_o,
    output logic               err_len_o,
    output logic [CNT_W-1:0]   frame_cnt_o
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               err_q,   err_d;
    logic [FRAME_W-1:0] fill_q,  fill_d;

    logic               w_accept;
    logic               w_fill_we;
    logic               w_slot_free;
    logic               w_load;
    logic               w_clear;
    logic [FRAME_W-1:0] w_merged;

    assign s_ready_o   = (state_q != HOLD);
    assign w_accept    = s_valid_i & s_ready_o;
    assign w_fill_we   = w_accept & (state_q == FILL);
    assign w_slot_free = ~m_valid_o | m_ready_i;

    // Fill buffer with the current word merged in; the final lane is narrow.
    for (genvar k = 0; k < NWORDS; k++) begin : g_lane
        localparam int LW = (k == NWORDS - 1) ? LAST_BITS : WORD_W;
        logic w_we;
        assign w_we = w_fill_we && (idx_q == IDX_W'(k));
        assign w_merged[k*WORD_W +: LW] = w_we ? s_data_i[LW-1:0]
                                               : fill_q[k*WORD_W +: LW];
    end

    assign fill_d = w_clear ? '0 : w_merged;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        w_load  = 1'b0;
        w_clear = 1'b0;
        case (state_q)
            FILL: begin
                if (w_accept) begin
                    if (s_last_i && (idx_q == LAST_IDX)) begin
                        idx_d = '0;
                        if (w_slot_free) begin
                            w_load  = 1'b1;
                            w_clear = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (s_last_i) begin
                        err_d   = 1'b1;
                        w_clear = 1'b1;
                        idx_d   = '0;
                    end else if (idx_q == LAST_IDX) begin
                        // Overlong frame: flag once, then swallow up to s_last.
                        err_d   = 1'b1;
                        w_clear = 1'b1;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_valid_o && m_ready_i) begin
                    w_load  = 1'b1;
                    w_clear = 1'b1;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (w_accept && s_last_i) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            err_q   <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign err_len_o = err_q;

    cluster_frame_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_load),
        .frame_i     (w_merged),
        .m_ready_i   (m_ready_i),
        .m_valid_o   (m_valid_o),
        .m_frame_o   (m_frame_o),
        .frame_cnt_o (frame_cnt_o)
    );

endmodule : cluster_frame_assembler
`default_nettype wire

// File: tb/tb_cluster_frame_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_cluster_frame_assembler
// Directed self-checking bench for cluster_frame_assembler.
// Revision: 1.0  initial release
// ============================================================================
module tb_cluster_frame_assembler;
    import cluster_io_pkg::*;

    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [WORD_W-1:0]  s_data = '0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [FRAME_W-1:0] m_frame;
    logic               err_len;
    logic [CNT_W-1:0]   frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int err_seen;
    int err_at;

    always #5 clk = ~clk;

    cluster_frame_assembler #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_frame_o   (m_frame),
        .err_len_o   (err_len),
        .frame_cnt_o (frame_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [FRAME_W-1:0] exp_frame(input logic [31:0] base);
        logic [FRAME_W-1:0] f;
        logic [31:0]        w;
        f = '0;
        for (int k = 0; k < NWORDS - 1; k++) f[k*WORD_W +: WORD_W] = base + 32'(k);
        w = base + 32'(NWORDS - 1);
        f[FRAME_W-1 -: LAST_BITS] = w[LAST_BITS-1:0];
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] base, input int n, input bit last_final);
        err_seen = 0;
        err_at   = -1;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(k);
            s_last  = last_final && (k == n - 1);
            tick();
            if (err_len) begin
                err_seen++;
                err_at = k;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        // reset values
        tick(); tick();
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_frame0", 64'(m_frame === '0), 64'd1);
        chk("rst_cnt",    64'(frame_cnt), 64'd0);
        chk("rst_err",    64'(err_len), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_sready", 64'(s_ready), 64'd1);

        // 1: basic frame, counting data, consumer ready
        m_ready = 1'b1;
        send(32'd0, NWORDS - 1, 1'b0);
        chk("t1_nolatch", 64'(m_valid), 64'd0);
        send(32'd59, 1, 1'b1);
        chk("t1_mvalid",  64'(m_valid), 64'd1);
        chk("t1_word1",   64'(m_frame[63:32]), 64'd1);
        chk("t1_top",     64'(m_frame[1893:1888]), 64'd59);
        chk("t1_frame",   64'(m_frame === exp_frame(32'd0)), 64'd1);
        tick();
        chk("t1_cnt",     64'(frame_cnt), 64'd1);
        chk("t1_mdrop",   64'(m_valid), 64'd0);

        // 2: last word all ones, only 6 bits land
        send(32'hFFFF_FFC4, NWORDS, 1'b1);
        chk("t2_top",     64'(m_frame[1893:1888]), 64'h3F);
        chk("t2_lane58",  64'(m_frame[1887:1856]), 64'hFFFF_FFFE);
        chk("t2_frame",   64'(m_frame === exp_frame(32'hFFFF_FFC4)), 64'd1);
        tick();
        chk("t2_cnt",     64'(frame_cnt), 64'd2);

        // 3: backpressure, second frame parks in HOLD
        m_ready = 1'b0;
        send(32'hA000_0000, NWORDS, 1'b1);
        chk("t3_f1valid", 64'(m_valid), 64'd1);
        send(32'hB000_0000, NWORDS, 1'b1);
        chk("t3_hold_rdy",64'(s_ready), 64'd0);
        tick(); tick(); tick();
        chk("t3_f1stable",64'(m_frame === exp_frame(32'hA000_0000)), 64'd1);
        chk("t3_vstable", 64'(m_valid), 64'd1);
        chk("t3_cnt_hold",64'(frame_cnt), 64'd2);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t3_f2",      64'(m_frame === exp_frame(32'hB000_0000)), 64'd1);
        chk("t3_vstay",   64'(m_valid), 64'd1);
        chk("t3_rdy",     64'(s_ready), 64'd1);
        chk("t3_cnt3",    64'(frame_cnt), 64'd3);
        tick();
        chk("t3_vheld",   64'(m_valid), 64'd1);
        m_ready = 1'b1;
        tick();
        chk("t3_cnt4",    64'(frame_cnt), 64'd4);
        chk("t3_vfall",   64'(m_valid), 64'd0);

        // 4: short frame
        send(32'hC000_0000, 11, 1'b1);
        chk("t4_errpulse",64'(err_len), 64'd1);
        chk("t4_errcount",64'(err_seen), 64'd1);
        chk("t4_errat",   64'(err_at), 64'd10);
        chk("t4_novalid", 64'(m_valid), 64'd0);
        tick();
        chk("t4_errdrop", 64'(err_len), 64'd0);
        send(32'hD000_0000, NWORDS, 1'b1);
        chk("t4_frame",   64'(m_frame === exp_frame(32'hD000_0000)), 64'd1);
        tick();
        chk("t4_cnt",     64'(frame_cnt), 64'd5);

        // 5: overlong frame drained
        send(32'hE000_0000, 70, 1'b1);
        chk("t5_errcount",64'(err_seen), 64'd1);
        chk("t5_errat",   64'(err_at), 64'd59);
        chk("t5_novalid", 64'(m_valid), 64'd0);
        send(32'hF000_0000, NWORDS, 1'b1);
        chk("t5_frame",   64'(m_frame === exp_frame(32'hF000_0000)), 64'd1);
        tick();
        chk("t5_cnt",     64'(frame_cnt), 64'd6);

        // 6: reset mid-frame
        send(32'h1234_0000, 30, 1'b0);
        rst = 1'b1;
        #2;
        chk("t6_cnt0",    64'(frame_cnt), 64'd0);
        chk("t6_frame0",  64'(m_frame === '0), 64'd1);
        chk("t6_mvalid",  64'(m_valid), 64'd0);
        tick();
        rst = 1'b0;
        send(32'h5555_0000, NWORDS, 1'b1);
        chk("t6_valid",   64'(m_valid), 64'd1);
        chk("t6_frame",   64'(m_frame === exp_frame(32'h5555_0000)), 64'd1);
        tick();
        chk("t6_cnt1",    64'(frame_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cluster_frame_assembler
`default_nettype wire
